stack_fetch_unit: RTL and testbench

- Reader side of the 9-bit instruction ROM interface. Drives the 8-bit program counter to the combinational instruction memory and captures the returned word.
- Decodes the word into push/operate fields and hands one decoded instruction per cycle to the stack datapath through a valid/ready handshake.
- Handles branch redirect, halt detection and PC wrap-around.
- Sits between the instruction ROM and the stack execute stage.

---
 rtl/stack_fetch_unit.sv | 108 ++++++++++
 tb/tb_stack_fetch_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/stack_fetch_unit.sv
// Fetch/decode front end for the 9-bit stack machine: drives the ROM address,
// decodes the returned word and hands it to execute over a valid/ready handshake.
module stack_fetch_unit #(
  parameter int                PC_W      = 8,
  parameter int                INST_W    = 9,
  parameter logic [INST_W-1:0] HALT_CODE = 9'h1FF,
  parameter logic [PC_W-1:0]   RESET_PC  = 8'h00
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  output logic [PC_W-1:0]   pc,
  input  logic [INST_W-1:0] inst,
  input  logic              branch_en,
  input  logic [PC_W-1:0]   branch_target,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic              is_push,
  output logic [7:0]        imm,
  output logic [3:0]        op_grp,
  output logic [3:0]        op_sel,
  output logic              is_halt,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t     state_reg;
  logic       adv;
  logic       push_next;
  logic       halt_next;
  logic [7:0] imm_next;
  logic [3:0] grp_next;
  logic [3:0] sel_next;

  assign adv = !dec_valid || dec_ready;

  // Fields that do not apply to the word's format are forced to zero so the
  // execute stage can compare them directly.
  always_comb begin
    push_next = ~inst[INST_W-1];
    halt_next = (inst == HALT_CODE);
    imm_next  = push_next ? inst[7:0] : 8'h00;
    grp_next  = push_next ? 4'h0 : inst[7:4];
    sel_next  = push_next ? 4'h0 : inst[3:0];
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg <= IDLE;
      pc        <= RESET_PC;
      dec_valid <= 1'b0;
      is_push   <= 1'b0;
      imm       <= 8'h00;
      op_grp    <= 4'h0;
      op_sel    <= 4'h0;
      is_halt   <= 1'b0;
      done      <= 1'b0;
    end else if (start) begin
      state_reg <= RUN;
      pc        <= RESET_PC;
      dec_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: ;
        RUN: begin
          // A redirect discards the word currently addressed by pc.
          if (branch_en) begin
            pc        <= branch_target;
            dec_valid <= 1'b0;
          end else if (adv) begin
            dec_valid <= 1'b1;
            is_push   <= push_next;
            imm       <= imm_next;
            op_grp    <= grp_next;
            op_sel    <= sel_next;
            is_halt   <= halt_next;
            if (halt_next) begin
              state_reg <= DRAIN;
            end else begin
              pc <= pc + PC_W'(1);
            end
          end
        end
        DRAIN: begin
          if (branch_en) begin
            pc        <= branch_target;
            dec_valid <= 1'b0;
            state_reg <= RUN;
          end else if (dec_valid && dec_ready && is_halt) begin
            dec_valid <= 1'b0;
            done      <= 1'b1;
            state_reg <= HALT;
          end
        end
        HALT: ;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_fetch_unit.sv
// Directed bench for stack_fetch_unit: behavioural ROM, a table of per-cycle
// vectors, then hand-written wrap-around and reset-during-drain sequences.
module tb_stack_fetch_unit;

  logic       CLK = 1'b0;
  logic       reset, start, branch_en, dec_ready;
  logic [7:0] branch_target;
  logic [7:0] pc;
  logic [8:0] inst;
  logic       dec_valid, is_push, is_halt, done;
  logic [7:0] imm;
  logic [3:0] op_grp, op_sel;

  logic [8:0] rom [256];
  assign inst = rom[pc];

  always #5 CLK = ~CLK;

  stack_fetch_unit dut (
    .CLK           (CLK),
    .reset         (reset),
    .start         (start),
    .pc            (pc),
    .inst          (inst),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .is_push       (is_push),
    .imm           (imm),
    .op_grp        (op_grp),
    .op_sel        (op_sel),
    .is_halt       (is_halt),
    .done          (done)
  );

  typedef struct {
    logic       st;
    logic       rdy;
    logic       br;
    logic [7:0] tgt;
    logic [7:0] e_pc;
    logic       e_v;
    logic       e_push;
    logic [7:0] e_imm;
    logic [3:0] e_grp;
    logic [3:0] e_sel;
    logic       e_h;
    logic       e_d;
  } vec_t;

  vec_t vecs [48];
  int   nvec   = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic st, input logic rdy, input logic br, input logic [7:0] tgt,
                     input logic [7:0] e_pc, input logic e_v, input logic e_push,
                     input logic [7:0] e_imm, input logic [3:0] e_grp, input logic [3:0] e_sel,
                     input logic e_h, input logic e_d);
    vecs[nvec] = '{st, rdy, br, tgt, e_pc, e_v, e_push, e_imm, e_grp, e_sel, e_h, e_d};
    nvec++;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] e_pc, input logic e_v,
                     input logic e_push, input logic [7:0] e_imm, input logic [3:0] e_grp,
                     input logic [3:0] e_sel, input logic e_h, input logic e_d, input bit verbose);
    logic [27:0] got, exp;
    got = {pc, dec_valid, is_push, imm, op_grp, op_sel, is_halt, done};
    exp = {e_pc, e_v, e_push, e_imm, e_grp, e_sel, e_h, e_d};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got pc=%h v=%b push=%b imm=%h grp=%h sel=%h halt=%b done=%b, expected pc=%h v=%b push=%b imm=%h grp=%h sel=%h halt=%b done=%b",
               name, pc, dec_valid, is_push, imm, op_grp, op_sel, is_halt, done,
               e_pc, e_v, e_push, e_imm, e_grp, e_sel, e_h, e_d);
    end else if (verbose) begin
      $display("ok   %s: pc=%h v=%b push=%b imm=%h grp=%h sel=%h halt=%b done=%b",
               name, pc, dec_valid, is_push, imm, op_grp, op_sel, is_halt, done);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 9'(i);
    rom[7]  = 9'h100;
    rom[8]  = 9'h112;
    rom[15] = 9'h194;
    rom[20] = 9'h182;
    rom[24] = 9'h1FF;

    // start, then straight-line pushes 0..6
    add(1, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 4'h0, 4'h0, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 1, 0, 8'h00, 8'(i + 1), 1, 1, 8'(i), 4'h0, 4'h0, 0, 0);
    // add at pc 7, then held for 3 cycles of backpressure
    add(0, 1, 0, 8'h00, 8'h08, 1, 0, 8'h00, 4'h0, 4'h0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 8'h00, 8'h08, 1, 0, 8'h00, 4'h0, 4'h0, 0, 0);
    add(0, 1, 0, 8'h00, 8'h09, 1, 0, 8'h00, 4'h1, 4'h2, 0, 0);
    // branch to 0x14 from pc 9: flush, then sln 2
    add(0, 1, 1, 8'h14, 8'h14, 0, 0, 8'h00, 4'h1, 4'h2, 0, 0);
    add(0, 1, 0, 8'h00, 8'h15, 1, 0, 8'h00, 4'h8, 4'h2, 0, 0);
    add(0, 1, 0, 8'h00, 8'h16, 1, 1, 8'h15, 4'h0, 4'h0, 0, 0);
    // branch back to 15: srn 4, then run up to the halt word at 24
    add(0, 1, 1, 8'h0F, 8'h0F, 0, 1, 8'h15, 4'h0, 4'h0, 0, 0);
    add(0, 1, 0, 8'h00, 8'h10, 1, 0, 8'h00, 4'h9, 4'h4, 0, 0);
    for (int i = 16; i < 24; i++) begin
      if (i == 20) add(0, 1, 0, 8'h00, 8'(i + 1), 1, 0, 8'h00, 4'h8, 4'h2, 0, 0);
      else         add(0, 1, 0, 8'h00, 8'(i + 1), 1, 1, 8'(i), 4'h0, 4'h0, 0, 0);
    end
    add(0, 1, 0, 8'h00, 8'h18, 1, 0, 8'h00, 4'hF, 4'hF, 1, 0);
    add(0, 0, 0, 8'h00, 8'h18, 1, 0, 8'h00, 4'hF, 4'hF, 1, 0);
    add(0, 0, 0, 8'h00, 8'h18, 1, 0, 8'h00, 4'hF, 4'hF, 1, 0);
    add(0, 1, 0, 8'h00, 8'h18, 0, 0, 8'h00, 4'hF, 4'hF, 1, 1);
    add(0, 1, 0, 8'h00, 8'h18, 0, 0, 8'h00, 4'hF, 4'hF, 1, 1);
    add(0, 1, 1, 8'h40, 8'h18, 0, 0, 8'h00, 4'hF, 4'hF, 1, 1);
    // start out of HALT
    add(1, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 4'hF, 4'hF, 1, 0);
    add(0, 1, 0, 8'h00, 8'h01, 1, 1, 8'h00, 4'h0, 4'h0, 0, 0);

    reset = 1'b1; start = 1'b0; branch_en = 1'b0; branch_target = 8'h00; dec_ready = 1'b0;
    step();
    chk("reset", 8'h00, 0, 0, 8'h00, 4'h0, 4'h0, 0, 0, 1'b1);
    reset = 1'b0;
    step();
    chk("idle_no_fetch", 8'h00, 0, 0, 8'h00, 4'h0, 4'h0, 0, 0, 1'b1);

    for (int r = 0; r < nvec; r++) begin
      start         = vecs[r].st;
      dec_ready     = vecs[r].rdy;
      branch_en     = vecs[r].br;
      branch_target = vecs[r].tgt;
      step();
      chk($sformatf("row%0d", r), vecs[r].e_pc, vecs[r].e_v, vecs[r].e_push, vecs[r].e_imm,
          vecs[r].e_grp, vecs[r].e_sel, vecs[r].e_h, vecs[r].e_d, 1'b1);
    end
    start = 1'b0; branch_en = 1'b0;

    // wrap: all-push ROM, run past 0xFF
    for (int i = 0; i < 256; i++) rom[i] = 9'(i);
    reset = 1'b1; step(); reset = 1'b0;
    start = 1'b1; dec_ready = 1'b1; step(); start = 1'b0;
    for (int i = 1; i <= 257; i++) begin
      step();
      chk($sformatf("wrap%0d", i), 8'(i), 1, 1, 8'(i - 1), 4'h0, 4'h0, 0, 0, (i >= 255));
    end

    // reset while draining a halt, with every other input asserted
    rom[8'h30] = 9'h1FF;
    branch_en = 1'b1; branch_target = 8'h30; step();
    chk("br_to_30", 8'h30, 0, 1, 8'h00, 4'h0, 4'h0, 0, 0, 1'b1);
    branch_en = 1'b0; step();
    chk("halt_load", 8'h30, 1, 0, 8'h00, 4'hF, 4'hF, 1, 0, 1'b1);
    dec_ready = 1'b0; step();
    chk("drain_hold", 8'h30, 1, 0, 8'h00, 4'hF, 4'hF, 1, 0, 1'b1);
    reset = 1'b1; start = 1'b1; branch_en = 1'b1; dec_ready = 1'b1; step();
    chk("reset_mid_drain", 8'h00, 0, 0, 8'h00, 4'h0, 4'h0, 0, 0, 1'b1);
    reset = 1'b0; start = 1'b0; branch_en = 1'b0; step();
    chk("idle_after_reset", 8'h00, 0, 0, 8'h00, 4'h0, 4'h0, 0, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
